yarp_mem_arbiter: RTL and testbench

//  Shares one memory port between the yarp_top instruction fetch and load/store interfaces (unified memory).

---
 rtl/yarp_pkg.sv | 32 +++
 rtl/yarp_arb_timer.sv | 57 +++++
 rtl/yarp_mem_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_yarp_mem_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/yarp_pkg.sv
// Shared types for the yarp core memory side: access-size codes and the
// unified-memory arbiter state/owner encodings.
package yarp_pkg;

    // Load/store access size carried on data_byte_en_i / mem_byte_en_o.
    typedef enum logic [1:0] {
        BYTE      = 2'b00,
        HALF_WORD = 2'b01,
        WORD      = 2'b11
    } mem_access_size_t;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_WAIT_GNT,
        ARB_WAIT_RSP
    } arb_state_t;

    typedef enum logic {
        OWNER_INSTR,
        OWNER_DATA
    } arb_owner_t;

    // Timeout counter width: wide enough for the limit, kept within 8..32 bits.
    function automatic int arb_timer_width(input int cyc);
        int w;
        w = $clog2(longint'(cyc) + 1);
        if (w < 8)  w = 8;
        if (w > 32) w = 32;
        return w;
    endfunction

endpackage

// File: rtl/yarp_arb_timer.sv
// Transaction timeout counter for yarp_mem_arbiter.
// count holds the number of cycles elapsed since capture, so the capture
// edge loads 1; it saturates at all-ones and never wraps. expired is high
// once count has reached TIMEOUT_CYC; expire_next says it will be high after
// the coming edge, letting the arbiter drop mem_req_o ahead of the abort.
// TIMEOUT_CYC = 0 removes the counter and ties both flags low.
module yarp_arb_timer
    import yarp_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired,
    output logic expire_next
);

    generate
        if (TIMEOUT_CYC == 0) begin : g_off
            assign expired     = 1'b0;
            assign expire_next = 1'b0;
        end else begin : g_on
            localparam int CNT_W = arb_timer_width(TIMEOUT_CYC);
            localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYC);

            logic [CNT_W-1:0] count;
            logic [CNT_W-1:0] count_next;

            // Next count: load 1 at capture, else saturating increment while enabled.
            // NOTE: every always_comb output gets a default first so no path infers a latch.
            always_comb begin
                count_next = count;
                if (clear) begin
                    count_next = CNT_W'(1);
                end else if (enable && (count != '1)) begin
                    count_next = count + CNT_W'(1);
                end
            end

            // Count register.
            // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    count <= '0;
                end else begin
                    count <= count_next;
                end
            end

            assign expired     = (count >= LIMIT);
            assign expire_next = (count_next >= LIMIT);
        end
    endgenerate

endmodule

// File: rtl/yarp_mem_arbiter.sv
// Unified-memory arbiter between the yarp_top fetch and load/store ports.
// One transaction outstanding; grants pulse combinationally in IDLE, the
// memory request/payload is registered, responses route to the owner.
// A transaction not finished TIMEOUT_CYC cycles after capture is aborted
// with *_err_o (TIMEOUT_CYC = 0 disables the timeout).
// Build option: YARP_MEM_ARB_RR_EN -- round-robin tie-break instead of
// fixed data-over-fetch priority.
module yarp_mem_arbiter
    import yarp_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              instr_req_i,
    input  logic [ADDR_W-1:0] instr_addr_i,
    output logic              instr_gnt_o,
    output logic              instr_rvalid_o,
    output logic [DATA_W-1:0] instr_rd_data_o,
    output logic              instr_err_o,
    input  logic              data_req_i,
    input  logic [ADDR_W-1:0] data_addr_i,
    input  logic [1:0]        data_byte_en_i,
    input  logic              data_wr_i,
    input  logic [DATA_W-1:0] data_wr_data_i,
    output logic              data_gnt_o,
    output logic              data_rvalid_o,
    output logic [DATA_W-1:0] data_rd_data_o,
    output logic              data_err_o,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [1:0]        mem_byte_en_o,
    output logic              mem_wr_o,
    output logic [DATA_W-1:0] mem_wr_data_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [DATA_W-1:0] mem_rd_data_i
);

    arb_state_t state;
    arb_state_t state_next;
    arb_owner_t owner;
    arb_owner_t winner;
    logic       capture;
    logic       complete;
    logic       abort;
    logic       mem_gnt_seen;
    logic       tmr_expired;
    logic       tmr_expire_next;

    // A grant only counts while our request is actually on the bus.
    assign mem_gnt_seen = mem_req_o && mem_gnt_i;

`ifdef YARP_MEM_ARB_RR_EN
    arb_owner_t last_winner;

    // Remember who won the last capture; reset value lets data win the first tie.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_winner <= OWNER_INSTR;
        end else if (capture) begin
            last_winner <= winner;
        end
    end
`endif

    // Pick the requester to capture when both are asking.
    always_comb begin
        winner = data_req_i ? OWNER_DATA : OWNER_INSTR;
`ifdef YARP_MEM_ARB_RR_EN
        if (instr_req_i && data_req_i) begin
            winner = (last_winner == OWNER_DATA) ? OWNER_INSTR : OWNER_DATA;
        end
`endif
    end

    // Next-state logic; completion is checked before timeout so it wins a tie.
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        complete   = 1'b0;
        abort      = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (instr_req_i || data_req_i) begin
                    capture    = 1'b1;
                    state_next = ARB_WAIT_GNT;
                end
            end
            ARB_WAIT_GNT: begin
                if (mem_gnt_seen && mem_rvalid_i) begin
                    complete   = 1'b1;
                    state_next = ARB_IDLE;
                end else if (tmr_expired) begin
                    abort      = 1'b1;
                    state_next = ARB_IDLE;
                end else if (mem_gnt_seen) begin
                    state_next = ARB_WAIT_RSP;
                end
            end
            ARB_WAIT_RSP: begin
                if (mem_rvalid_i) begin
                    complete   = 1'b1;
                    state_next = ARB_IDLE;
                end else if (tmr_expired) begin
                    abort      = 1'b1;
                    state_next = ARB_IDLE;
                end
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    // State and owner registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ARB_IDLE;
            owner <= OWNER_INSTR;
        end else begin
            state <= state_next;
            if (capture) begin
                owner <= winner;
            end
        end
    end

    // Registered memory request and payload; request drops on grant or just before timeout.
    // NOTE: the payload flops are reset as well, so mem_* read 0 straight out of reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_req_o     <= 1'b0;
            mem_addr_o    <= '0;
            mem_byte_en_o <= '0;
            mem_wr_o      <= 1'b0;
            mem_wr_data_o <= '0;
        end else if (capture) begin
            mem_req_o <= !tmr_expire_next;
            if (winner == OWNER_DATA) begin
                mem_addr_o    <= data_addr_i;
                mem_byte_en_o <= data_byte_en_i;
                mem_wr_o      <= data_wr_i;
                mem_wr_data_o <= data_wr_data_i;
            end else begin
                mem_addr_o    <= instr_addr_i;
                mem_byte_en_o <= '0;
                mem_wr_o      <= 1'b0;
                mem_wr_data_o <= '0;
            end
        end else if (mem_gnt_seen || tmr_expire_next) begin
            mem_req_o <= 1'b0;
        end
    end

    // Grant and response steering to the requester ports.
    always_comb begin
        instr_gnt_o     = capture && (winner == OWNER_INSTR);
        data_gnt_o      = capture && (winner == OWNER_DATA);
        instr_rvalid_o  = (complete || abort) && (owner == OWNER_INSTR);
        data_rvalid_o   = (complete || abort) && (owner == OWNER_DATA);
        instr_err_o     = abort && (owner == OWNER_INSTR);
        data_err_o      = abort && (owner == OWNER_DATA);
        instr_rd_data_o = '0;
        data_rd_data_o  = '0;
        if (complete && (owner == OWNER_INSTR)) begin
            instr_rd_data_o = mem_rd_data_i;
        end
        if (complete && (owner == OWNER_DATA)) begin
            data_rd_data_o = mem_rd_data_i;
        end
    end

    yarp_arb_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk         (clk),
        .reset_n     (reset_n),
        .clear       (capture),
        .enable      (state != ARB_IDLE),
        .expired     (tmr_expired),
        .expire_next (tmr_expire_next)
    );

`ifndef SYNTHESIS
    a_instr_hold: assert property (@(posedge clk) disable iff (!reset_n)
        (instr_req_i && !instr_gnt_o) |=> (!instr_req_i || $stable(instr_addr_i)));
    a_data_hold: assert property (@(posedge clk) disable iff (!reset_n)
        (data_req_i && !data_gnt_o) |=>
        (!data_req_i || $stable({data_addr_i, data_byte_en_i, data_wr_i, data_wr_data_i})));
    a_data_size: assert property (@(posedge clk) disable iff (!reset_n)
        data_req_i |-> (data_byte_en_i inside {BYTE, HALF_WORD, WORD}));
    a_one_gnt: assert property (@(posedge clk) disable iff (!reset_n)
        !(instr_gnt_o && data_gnt_o));
`endif

endmodule

// File: tb/tb_yarp_mem_arbiter.sv
// Self-checking bench for yarp_mem_arbiter: a table of per-cycle vectors
// plus hand-written sequences for arbitration rounds, timeout, reset and
// the timeout-disabled build. dut uses TIMEOUT_CYC=4, dut0 TIMEOUT_CYC=0;
// both see the same stimulus.
`timescale 1ns/1ps
module tb_yarp_mem_arbiter;
    import yarp_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        instr_req_i;
    logic [31:0] instr_addr_i;
    logic        data_req_i;
    logic [31:0] data_addr_i;
    logic [1:0]  data_byte_en_i;
    logic        data_wr_i;
    logic [31:0] data_wr_data_i;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rd_data_i;

    logic        instr_gnt_o, instr_rvalid_o, instr_err_o;
    logic [31:0] instr_rd_data_o;
    logic        data_gnt_o, data_rvalid_o, data_err_o;
    logic [31:0] data_rd_data_o;
    logic        mem_req_o, mem_wr_o;
    logic [31:0] mem_addr_o, mem_wr_data_o;
    logic [1:0]  mem_byte_en_o;

    logic        z_instr_gnt_o, z_instr_rvalid_o, z_instr_err_o;
    logic [31:0] z_instr_rd_data_o;
    logic        z_data_gnt_o, z_data_rvalid_o, z_data_err_o;
    logic [31:0] z_data_rd_data_o;
    logic        z_mem_req_o, z_mem_wr_o;
    logic [31:0] z_mem_addr_o, z_mem_wr_data_o;
    logic [1:0]  z_mem_byte_en_o;

    always #5 clk = ~clk;

    yarp_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i),
        .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o),
        .instr_rd_data_o(instr_rd_data_o), .instr_err_o(instr_err_o),
        .data_req_i(data_req_i), .data_addr_i(data_addr_i),
        .data_byte_en_i(data_byte_en_i), .data_wr_i(data_wr_i),
        .data_wr_data_i(data_wr_data_i), .data_gnt_o(data_gnt_o),
        .data_rvalid_o(data_rvalid_o), .data_rd_data_o(data_rd_data_o),
        .data_err_o(data_err_o), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
        .mem_byte_en_o(mem_byte_en_o), .mem_wr_o(mem_wr_o),
        .mem_wr_data_o(mem_wr_data_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rd_data_i(mem_rd_data_i)
    );

    yarp_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(0)) dut0 (
        .clk(clk), .reset_n(reset_n),
        .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i),
        .instr_gnt_o(z_instr_gnt_o), .instr_rvalid_o(z_instr_rvalid_o),
        .instr_rd_data_o(z_instr_rd_data_o), .instr_err_o(z_instr_err_o),
        .data_req_i(data_req_i), .data_addr_i(data_addr_i),
        .data_byte_en_i(data_byte_en_i), .data_wr_i(data_wr_i),
        .data_wr_data_i(data_wr_data_i), .data_gnt_o(z_data_gnt_o),
        .data_rvalid_o(z_data_rvalid_o), .data_rd_data_o(z_data_rd_data_o),
        .data_err_o(z_data_err_o), .mem_req_o(z_mem_req_o), .mem_addr_o(z_mem_addr_o),
        .mem_byte_en_o(z_mem_byte_en_o), .mem_wr_o(z_mem_wr_o),
        .mem_wr_data_o(z_mem_wr_data_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rd_data_i(mem_rd_data_i)
    );

    typedef struct packed {
        logic        instr_req;
        logic [31:0] instr_addr;
        logic        data_req;
        logic [31:0] data_addr;
        logic [1:0]  data_byte_en;
        logic        data_wr;
        logic [31:0] data_wr_data;
        logic        mem_gnt;
        logic        mem_rvalid;
        logic [31:0] mem_rd_data;
    } ins_t;

    typedef struct packed {
        logic        instr_gnt;
        logic        instr_rvalid;
        logic [31:0] instr_rd_data;
        logic        instr_err;
        logic        data_gnt;
        logic        data_rvalid;
        logic [31:0] data_rd_data;
        logic        data_err;
        logic        mem_req;
        logic [31:0] mem_addr;
        logic [1:0]  mem_byte_en;
        logic        mem_wr;
        logic [31:0] mem_wr_data;
    } outs_t;

    typedef struct packed {
        ins_t  ins;
        outs_t exp;
    } vec_t;

    vec_t  vecs[$];
    ins_t  ti;
    outs_t te;
    int    checks = 0;
    int    errors = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input ins_t v);
        instr_req_i    = v.instr_req;
        instr_addr_i   = v.instr_addr;
        data_req_i     = v.data_req;
        data_addr_i    = v.data_addr;
        data_byte_en_i = v.data_byte_en;
        data_wr_i      = v.data_wr;
        data_wr_data_i = v.data_wr_data;
        mem_gnt_i      = v.mem_gnt;
        mem_rvalid_i   = v.mem_rvalid;
        mem_rd_data_i  = v.mem_rd_data;
    endtask

    // Apply one cycle of inputs just after the rising edge, return at the falling edge.
    task automatic step(input ins_t v);
        @(posedge clk);
        #1;
        drive(v);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        drive('0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    function automatic outs_t sample_dut();
        outs_t o;
        o.instr_gnt     = instr_gnt_o;
        o.instr_rvalid  = instr_rvalid_o;
        o.instr_rd_data = instr_rd_data_o;
        o.instr_err     = instr_err_o;
        o.data_gnt      = data_gnt_o;
        o.data_rvalid   = data_rvalid_o;
        o.data_rd_data  = data_rd_data_o;
        o.data_err      = data_err_o;
        o.mem_req       = mem_req_o;
        o.mem_addr      = mem_addr_o;
        o.mem_byte_en   = mem_byte_en_o;
        o.mem_wr        = mem_wr_o;
        o.mem_wr_data   = mem_wr_data_o;
        return o;
    endfunction

    function automatic outs_t off(input outs_t o);
        outs_t r;
        r = o;
        r.instr_gnt = 1'b0; r.instr_rvalid = 1'b0; r.instr_rd_data = '0; r.instr_err = 1'b0;
        r.data_gnt  = 1'b0; r.data_rvalid  = 1'b0; r.data_rd_data  = '0; r.data_err  = 1'b0;
        return r;
    endfunction

    task automatic add(input ins_t i, input outs_t e);
        vec_t v;
        v.ins = i;
        v.exp = e;
        vecs.push_back(v);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        rr_en;
        logic [1:0]  exp_gnt;
        logic [31:0] exp_addr;
        int          bad;

`ifdef YARP_MEM_ARB_RR_EN
        rr_en = 1'b1;
`else
        rr_en = 1'b0;
`endif

        // ---------------- vector table ----------------
        te = '0;
        ti = '0; add(ti, te);                                             // idle after reset
        // fetch only: capture, gnt, rvalid 0x13
        ti = '0; ti.instr_req = 1; ti.instr_addr = 32'h1000;
        te = off(te); te.instr_gnt = 1; add(ti, te);
        ti = '0; ti.mem_gnt = 1;
        te = off(te); te.mem_req = 1; te.mem_addr = 32'h1000; add(ti, te);
        ti = '0; ti.mem_rvalid = 1; ti.mem_rd_data = 32'h0000_0013;
        te = off(te); te.mem_req = 0; te.instr_rvalid = 1; te.instr_rd_data = 32'h0000_0013; add(ti, te);
        ti = '0; te = off(te); add(ti, te);
        // both request: data store wins, fetch held until the IDLE after data_rvalid_o
        ti = '0; ti.instr_req = 1; ti.instr_addr = 32'h1004;
        ti.data_req = 1; ti.data_addr = 32'h2000; ti.data_byte_en = WORD;
        ti.data_wr = 1; ti.data_wr_data = 32'hDEAD_BEEF;
        te = off(te); te.data_gnt = 1; add(ti, te);
        ti = '0; ti.instr_req = 1; ti.instr_addr = 32'h1004; ti.mem_gnt = 1;
        te = off(te); te.mem_req = 1; te.mem_addr = 32'h2000; te.mem_byte_en = WORD;
        te.mem_wr = 1; te.mem_wr_data = 32'hDEAD_BEEF; add(ti, te);
        ti = '0; ti.instr_req = 1; ti.instr_addr = 32'h1004;
        ti.mem_rvalid = 1; ti.mem_rd_data = 32'h1234_5678;
        te = off(te); te.mem_req = 0; te.data_rvalid = 1; te.data_rd_data = 32'h1234_5678; add(ti, te);
        ti = '0; ti.instr_req = 1; ti.instr_addr = 32'h1004;
        te = off(te); te.instr_gnt = 1; add(ti, te);
        // gnt and rvalid together on the first mem_req_o cycle
        ti = '0; ti.mem_gnt = 1; ti.mem_rvalid = 1; ti.mem_rd_data = 32'h0BAD_F00D;
        te = off(te); te.mem_req = 1; te.mem_addr = 32'h1004; te.mem_byte_en = 2'b00;
        te.mem_wr = 0; te.mem_wr_data = 32'h0;
        te.instr_rvalid = 1; te.instr_rd_data = 32'h0BAD_F00D; add(ti, te);
        // next capture on the following cycle: byte load
        ti = '0; ti.data_req = 1; ti.data_addr = 32'h3000; ti.data_byte_en = BYTE;
        te = off(te); te.mem_req = 0; te.data_gnt = 1; add(ti, te);
        ti = '0; ti.mem_gnt = 1;
        te = off(te); te.mem_req = 1; te.mem_addr = 32'h3000; add(ti, te);
        ti = '0; ti.mem_rvalid = 1; ti.mem_rd_data = 32'h0000_00AB;
        te = off(te); te.mem_req = 0; te.data_rvalid = 1; te.data_rd_data = 32'h0000_00AB; add(ti, te);
        // stray rvalid in IDLE is ignored
        ti = '0; ti.mem_rvalid = 1; ti.mem_rd_data = 32'h0000_0077;
        te = off(te); add(ti, te);
        // rvalid in WAIT_GNT without gnt is ignored
        ti = '0; ti.instr_req = 1; ti.instr_addr = 32'h1008;
        te = off(te); te.instr_gnt = 1; add(ti, te);
        ti = '0; ti.mem_rvalid = 1; ti.mem_rd_data = 32'h0000_0099;
        te = off(te); te.mem_req = 1; te.mem_addr = 32'h1008; add(ti, te);
        ti = '0; ti.mem_gnt = 1;
        te = off(te); add(ti, te);
        ti = '0; ti.mem_rvalid = 1; ti.mem_rd_data = 32'h0000_0055;
        te = off(te); te.mem_req = 0; te.instr_rvalid = 1; te.instr_rd_data = 32'h0000_0055; add(ti, te);

        // ---------------- reset state ----------------
        reset_n = 1'b0;
        drive('0);
        @(negedge clk);
        check("reset_outputs", 256'(sample_dut()), 256'(outs_t'('0)));
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // ---------------- table ----------------
        for (int k = 0; k < vecs.size(); k++) begin
            step(vecs[k].ins);
            check($sformatf("vec%0d", k), 256'(sample_dut()), 256'(vecs[k].exp));
        end

        // ---------------- simultaneous requests, 4 rounds ----------------
        do_reset();
        for (int r = 0; r < 4; r++) begin
            ti = '0;
            ti.instr_req = 1; ti.instr_addr = 32'h100 + 32'(4 * r);
            ti.data_req = 1; ti.data_addr = 32'h200 + 32'(4 * r); ti.data_byte_en = WORD;
            step(ti);
            exp_gnt  = (!rr_en || (r % 2 == 0)) ? 2'b01 : 2'b10;
            exp_addr = exp_gnt[0] ? 32'h200 + 32'(4 * r) : 32'h100 + 32'(4 * r);
            check($sformatf("tie_gnt%0d", r), 256'({instr_gnt_o, data_gnt_o}), 256'(exp_gnt));
            ti = '0; ti.mem_gnt = 1; ti.mem_rvalid = 1; ti.mem_rd_data = 32'(r);
            step(ti);
            check($sformatf("tie_rvalid%0d", r), 256'({instr_rvalid_o, data_rvalid_o}), 256'(exp_gnt));
            check($sformatf("tie_addr%0d", r), 256'(mem_addr_o), 256'(exp_addr));
        end

        // ---------------- timeout (TIMEOUT_CYC=4), memory never grants ----------------
        do_reset();
        ti = '0; ti.data_req = 1; ti.data_addr = 32'h4000; ti.data_byte_en = HALF_WORD;
        step(ti);
        check("to_gnt", 256'(data_gnt_o), 256'(1'b1));
        for (int c = 1; c <= 3; c++) begin
            ti = '0; ti.mem_rd_data = 32'hFFFF_FFFF;
            step(ti);
            check($sformatf("to_wait%0d", c), 256'({mem_req_o, data_rvalid_o, data_err_o}), 256'(3'b100));
        end
        ti = '0; ti.mem_rd_data = 32'hFFFF_FFFF;
        step(ti);
        check("to_abort", 256'({mem_req_o, data_rvalid_o, data_err_o}), 256'(3'b011));
        check("to_abort_data", 256'(data_rd_data_o), 256'(32'h0));
        for (int c = 0; c < 2; c++) begin
            ti = '0; ti.mem_rvalid = 1; ti.mem_rd_data = 32'hFFFF_FFFF;
            step(ti);
            check($sformatf("to_late%0d", c), 256'({instr_rvalid_o, data_rvalid_o, mem_req_o}), 256'(3'b000));
        end

        // ---------------- reset during WAIT_RSP ----------------
        do_reset();
        ti = '0; ti.data_req = 1; ti.data_addr = 32'h5000; ti.data_byte_en = WORD;
        step(ti);
        ti = '0; ti.mem_gnt = 1;
        step(ti);
        check("rst_pre_addr", 256'(mem_addr_o), 256'(32'h5000));
        ti = '0;
        step(ti);
        #1;
        reset_n = 1'b0;
        #1;
        check("rst_mid_outputs", 256'(sample_dut()), 256'(outs_t'('0)));
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        ti = '0; ti.mem_rvalid = 1; ti.mem_rd_data = 32'hCAFE_0000;
        step(ti);
        check("rst_stray_rvalid", 256'(sample_dut()), 256'(outs_t'('0)));

        // ---------------- timeout disabled (dut0), long grant stall ----------------
        do_reset();
        ti = '0; ti.instr_req = 1; ti.instr_addr = 32'h6000;
        step(ti);
        check("nt_gnt", 256'(z_instr_gnt_o), 256'(1'b1));
        bad = 0;
        for (int c = 0; c < 1000; c++) begin
            step('0);
            if (z_instr_rvalid_o || z_instr_err_o || !z_mem_req_o) bad++;
        end
        check("nt_stall_1000", 256'(bad), 256'(0));
        ti = '0; ti.mem_gnt = 1;
        step(ti);
        check("nt_req_at_gnt", 256'({z_mem_req_o, z_instr_rvalid_o}), 256'(2'b10));
        ti = '0; ti.mem_rvalid = 1; ti.mem_rd_data = 32'h6666_6666;
        step(ti);
        check("nt_done", 256'({z_instr_rvalid_o, z_instr_err_o, z_mem_req_o}), 256'(3'b100));
        check("nt_data", 256'(z_instr_rd_data_o), 256'(32'h6666_6666));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
